// File: rtl/alu_result_sel_pipe_if.sv
// Handshake bundle between the ALU functional units, the result selector and writeback.
// The master drives operands/opcode and consumes results; the slave is the selector.
interface alu_result_sel_pipe_if #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned NUM_OPS   = 12,
    parameter int unsigned ERR_CNT_W = 8
);
    localparam int unsigned OpW = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

    logic [NUM_OPS*WIDTH-1:0] res_in;
    logic [NUM_OPS-1:0]       sel;
    logic                     in_valid;
    logic                     in_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         result;
    logic [OpW-1:0]           op_idx;
    logic                     flag_zero;
    logic                     flag_neg;
    logic                     flag_err;
    logic [ERR_CNT_W-1:0]     err_cnt;

    modport master (
        output res_in, sel, in_valid, out_ready,
        input  in_ready, out_valid, result, op_idx, flag_zero, flag_neg, flag_err, err_cnt
    );

    modport slave (
        input  res_in, sel, in_valid, out_ready,
        output in_ready, out_valid, result, op_idx, flag_zero, flag_neg, flag_err, err_cnt
    );
endinterface

// File: rtl/alu_result_sel_pipe.sv
// One-hot ALU result selector with illegal-opcode detection, status flags and a small
// output FIFO behind a valid/ready handshake.
module alu_result_sel_pipe #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned NUM_OPS   = 12,
    parameter int unsigned CLEAR_IDX = 11,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned ERR_CNT_W = 8
) (
    input logic                 clk,
    input logic                 rst,
    alu_result_sel_pipe_if.slave bus
);
    localparam int unsigned OpW  = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0]     mem_result_q [DEPTH];
    logic [OpW-1:0]       mem_op_q     [DEPTH];
    logic                 mem_err_q    [DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      count_q, count_d;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic             sel_legal;
    logic [OpW-1:0]   sel_idx;
    logic [WIDTH-1:0] sel_lane;
    logic [WIDTH-1:0] push_result;
    logic [OpW-1:0]   push_op;
    logic             push_err;
    logic             push, pop;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    always_comb begin
        sel_legal = (bus.sel != '0) && ((bus.sel & (bus.sel - NUM_OPS'(1))) == '0);
        sel_idx   = '0;
        sel_lane  = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (bus.sel[i]) begin
                sel_idx  = OpW'(i);
                sel_lane = bus.res_in[i*WIDTH +: WIDTH];
            end
        end
        push_result = (sel_legal && (sel_idx != OpW'(CLEAR_IDX))) ? sel_lane : '0;
        push_op     = sel_legal ? sel_idx : '0;
        push_err    = !sel_legal;
    end

    always_comb begin
        bus.in_ready  = (count_q != CntW'(DEPTH));
        bus.out_valid = (count_q != '0);
        push          = bus.in_valid && bus.in_ready;
        pop           = bus.out_valid && bus.out_ready;
        count_d       = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_result_q[i] <= '0;
                mem_op_q[i]     <= '0;
                mem_err_q[i]    <= 1'b0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            if (push) begin
                mem_result_q[wr_ptr_q] <= push_result;
                mem_op_q[wr_ptr_q]     <= push_op;
                mem_err_q[wr_ptr_q]    <= push_err;
                wr_ptr_q               <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
            if (push && push_err && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    // Flags derive from the stored result, which is exactly what push would compute.
    always_comb begin
        bus.result    = mem_result_q[rd_ptr_q];
        bus.op_idx    = mem_op_q[rd_ptr_q];
        bus.flag_err  = mem_err_q[rd_ptr_q];
        bus.flag_zero = (mem_result_q[rd_ptr_q] == '0);
        bus.flag_neg  = mem_result_q[rd_ptr_q][WIDTH-1];
        bus.err_cnt   = err_cnt_q;
    end
endmodule

// File: tb/tb_alu_result_sel_pipe.sv
// Directed-vector bench: the driver queues hand-computed expectations, an independent
// monitor pops and compares whenever an output transfer happens.
module tb_alu_result_sel_pipe;
    logic clk;
    logic rst;

    alu_result_sel_pipe_if #(.WIDTH(16), .NUM_OPS(12), .ERR_CNT_W(8)) bus ();

    alu_result_sel_pipe #(
        .WIDTH    (16),
        .NUM_OPS  (12),
        .CLEAR_IDX(11),
        .DEPTH    (2),
        .ERR_CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [15:0] r;
        logic [3:0]  op;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic set_bg();
        for (int i = 0; i < 12; i++) bus.res_in[i*16 +: 16] = 16'(i * 257 + 17);
    endtask

    // Drive one beat starting just after a rising edge; it is accepted at the next edge.
    task automatic push(input int lane, input logic [15:0] data, input logic [11:0] s,
                        input logic [15:0] er, input logic [3:0] eo, input logic ee,
                        input logic acc);
        exp_t e;
        set_bg();
        bus.res_in[lane*16 +: 16] = data;
        bus.sel      = s;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("in_ready_at_push", {31'b0, bus.in_ready}, {31'b0, acc});
        if (acc) begin
            e.r = er; e.op = eo; e.err = ee;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.sel      = '0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        check("drain_sb_empty", sb.size(), 0);
        @(negedge clk);
        check("drain_out_valid", {31'b0, bus.out_valid}, 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_output", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", {16'b0, bus.result}, {16'b0, e.r});
                check("op_idx", {28'b0, bus.op_idx}, {28'b0, e.op});
                check("flag_zero", {31'b0, bus.flag_zero}, {31'b0, (e.r == 16'h0)});
                check("flag_neg", {31'b0, bus.flag_neg}, {31'b0, e.r[15]});
                check("flag_err", {31'b0, bus.flag_err}, {31'b0, e.err});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.res_in    = '0;
        bus.sel       = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_out_valid", {31'b0, bus.out_valid}, 0);
        check("rst_in_ready", {31'b0, bus.in_ready}, 1);
        check("rst_err_cnt", {24'b0, bus.err_cnt}, 0);
        check("rst_result", {16'b0, bus.result}, 0);
        check("rst_op_idx", {28'b0, bus.op_idx}, 0);
        check("rst_flag_zero", {31'b0, bus.flag_zero}, 1);
        check("rst_flag_neg", {31'b0, bus.flag_neg}, 0);
        check("rst_flag_err", {31'b0, bus.flag_err}, 0);
        @(posedge clk);
        #1;

        // Legal ops back to back.
        bus.out_ready = 1'b1;
        push(7, 16'h8001, 12'h080, 16'h8001, 4'd7, 1'b0, 1'b1);
        push(0, 16'h00F0, 12'h001, 16'h00F0, 4'd0, 1'b0, 1'b1);
        idle();
        drain();

        // CLEAR and illegal opcodes.
        push(11, 16'hFFFF, 12'h800, 16'h0000, 4'd11, 1'b0, 1'b1);
        push(0, 16'h1234, 12'h003, 16'h0000, 4'd0, 1'b1, 1'b1);
        push(0, 16'h5678, 12'h000, 16'h0000, 4'd0, 1'b1, 1'b1);
        idle();
        check("err_cnt_two", {24'b0, bus.err_cnt}, 2);
        drain();

        // Backpressure: only two entries fit.
        bus.out_ready = 1'b0;
        push(1, 16'hAAAA, 12'h002, 16'hAAAA, 4'd1, 1'b0, 1'b1);
        check("latency_out_valid", {31'b0, bus.out_valid}, 1);
        push(2, 16'hBBBB, 12'h004, 16'hBBBB, 4'd2, 1'b0, 1'b1);
        push(3, 16'hCCCC, 12'h008, 16'hCCCC, 4'd3, 1'b0, 1'b0);
        idle();
        check("full_in_ready", {31'b0, bus.in_ready}, 0);
        check("full_err_cnt_unchanged", {24'b0, bus.err_cnt}, 2);
        drain();

        // Simultaneous push and pop at count=1.
        bus.out_ready = 1'b0;
        push(4, 16'h0D0D, 12'h010, 16'h0D0D, 4'd4, 1'b0, 1'b1);
        bus.out_ready = 1'b1;
        push(5, 16'h0E0E, 12'h020, 16'h0E0E, 4'd5, 1'b0, 1'b1);
        push(6, 16'h0F0F, 12'h040, 16'h0F0F, 4'd6, 1'b0, 1'b1);
        idle();
        check("simul_out_valid", {31'b0, bus.out_valid}, 1);
        check("simul_in_ready", {31'b0, bus.in_ready}, 1);
        drain();

        // Asynchronous reset with two entries queued.
        bus.out_ready = 1'b0;
        push(8, 16'h1111, 12'h100, 16'h1111, 4'd8, 1'b0, 1'b1);
        push(9, 16'h2222, 12'h200, 16'h2222, 4'd9, 1'b0, 1'b1);
        idle();
        check("pre_rst_out_valid", {31'b0, bus.out_valid}, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", {31'b0, bus.out_valid}, 0);
        check("async_rst_in_ready", {31'b0, bus.in_ready}, 1);
        check("async_rst_err_cnt", {24'b0, bus.err_cnt}, 0);
        check("async_rst_result", {16'b0, bus.result}, 0);
        check("async_rst_flag_zero", {31'b0, bus.flag_zero}, 1);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        push(3, 16'h7ABC, 12'h008, 16'h7ABC, 4'd3, 1'b0, 1'b1);
        push(10, 16'hC000, 12'h400, 16'hC000, 4'd10, 1'b0, 1'b1);
        idle();
        drain();

        // Saturating illegal-opcode counter.
        for (int i = 0; i < 260; i++) begin
            push(0, 16'h4321, (i % 2 == 0) ? 12'h000 : 12'h0C0, 16'h0000, 4'd0, 1'b1, 1'b1);
            if (i == 253) check("err_cnt_254", {24'b0, bus.err_cnt}, 254);
            if (i == 254) check("err_cnt_255", {24'b0, bus.err_cnt}, 255);
        end
        idle();
        check("err_cnt_saturated", {24'b0, bus.err_cnt}, 255);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_result_sel_pipe.md
# alu_result_sel_pipe

Parametrised, registered result selector for the ALU datapath. It picks one of NUM_OPS functional-unit results using a one-hot opcode and flags illegal opcodes instead of silently defaulting. It tags each result with zero/negative status and buffers results in a DEPTH-entry FIFO behind a valid/ready handshake. It sits between the parallel functional units (AND/OR/…/ADD/SUB/shifts) and the ALU output/writeback stage.

## Interface
- WIDTH, 16, data width of each operand result and of the output
- NUM_OPS, 12, number of one-hot opcode bits / result lanes
- CLEAR_IDX, 11, opcode bit that forces a zero result (CLEAR op)
- DEPTH, 2, output FIFO entries; power of two, ≥2
- ERR_CNT_W, 8, width of saturating illegal-opcode counter
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- res_in  in  NUM_OPS*WIDTH  packed lane results; lane i = bits [i*WIDTH +: WIDTH]
- sel  in  NUM_OPS  one-hot opcode
- in_valid  in  1  res_in/sel valid this cycle
- in_ready  out  1  block can accept (count < DEPTH)
- out_valid  out  1  head entry present (count > 0)
- out_ready  in  1  consumer takes head entry
- result  out  WIDTH  head entry result
- op_idx  out  clog2(NUM_OPS)  head entry binary-encoded opcode index
- flag_zero  out  1  head result == 0
- flag_neg  out  1  head result MSB
- flag_err  out  1  head entry had an illegal opcode
- err_cnt  out  ERR_CNT_W  accepted illegal opcodes, saturating

## Operation
- Push: in_valid && in_ready at a rising edge; the entry is computed combinationally from res_in/sel of that cycle and written at the tail.
- Legal sel (exactly one bit i set): result = lane i; op_idx = i; err = 0. If i == CLEAR_IDX, result = 0 regardless of lane data.
- Illegal sel (zero bits or ≥2 bits set): result = 0, op_idx = 0, err = 1; err_cnt increments on that push and saturates at all-ones.
- flag_zero and flag_neg are computed from the stored result at push. An illegal entry gives flag_zero=1, flag_neg=0.
- Pop: out_valid && out_ready at a rising edge; the head advances.
- Simultaneous push and pop with 0 < count < DEPTH: both occur and count is unchanged.
- When full, in_ready=0, so a push is impossible even if a pop happens in the same cycle (no pass-through).
- When empty, no pop occurs; out_ready is ignored.
- Read/write pointers wrap modulo DEPTH. count is held in clog2(DEPTH)+1 bits.
- Head output fields hold the value of the last written entry at the head slot. They are don't-care when out_valid=0 but must not be X after reset.
- in_valid with in_ready=0 is ignored; err_cnt does not change.

## Timing
- Reset (async assert, released synchronously to clk by the system):
  - count=0, pointers=0, err_cnt=0, all FIFO storage=0.
  - Therefore out_valid=0, in_ready=1, result=0, op_idx=0, flag_zero=1, flag_neg=0, flag_err=0.
- Latency: when empty, a push at edge N gives out_valid=1 with the entry on outputs after edge N (visible in cycle N+1).
- Throughput: one entry per cycle sustained while out_ready=1.
- in_ready and out_valid are combinational from count only. There is no combinational path from in_valid to out_valid, or from out_ready to in_ready.
- Reset asserted mid-stream discards all buffered entries immediately; outputs go to reset values without waiting for clk.

## Test plan
- Reset then idle:
  - Required: out_valid=0, in_ready=1, err_cnt=0, result=0, flag_zero=1.
- Legal ops, out_ready=1:
  - Stimulus: lane 7 (ADD) = 16'h8001 with sel=12'h080; then sel=12'h001 with lane 0 = 16'h00F0.
  - Required: next cycles give result=8001/op_idx=7/flag_neg=1, then 00F0/op_idx=0/flag_zero=0, back-to-back.
- CLEAR and illegal sel:
  - Stimulus: sel=12'h800 with lane 11 = 16'hFFFF; sel=12'h003; sel=12'h000.
  - Required: results 0,0,0; flag_err=0,1,1; err_cnt=2.
- Backpressure and full:
  - Stimulus: out_ready=0, push 3 words A,B,C with DEPTH=2.
  - Required: only A,B accepted; in_ready=0 after the 2nd push; raising out_ready drains A then B in order.
  - Simultaneous push/pop at count=1 keeps count=1 and preserves order.
- Saturation: 260 illegal pushes with ERR_CNT_W=8 -> err_cnt stops at 255.
- Reset mid-operation: assert rst asynchronously with 2 entries queued -> out_valid drops before the next clk edge; err_cnt=0; later pushes behave as after a fresh reset.
